rr_arb4_idx: RTL and testbench
==============================

// Module: rr_arb4_idx
// PURPOSE
//   4-requester round-robin arbiter with grant hold and timeout.
//   Produces a binary grant index plus a valid qualifier. These drive the
//   a[1:0]/en inputs of the downstream 2-to-4 decoder, which expands them to
//   a one-hot grant.
//   Grant is held until the owner signals done, drops its request, or times out.
// PARAMETERS
//   MAX_HOLD  15  max cycles a grant may be held (1..255); 0 = timeout disabled
// PORTS
//   clk      in   1  system clock, all logic on rising edge
//   rst_n    in   1  synchronous reset, active-low
//   req      in   4  request vector, bit i = requester i
//   done     in   1  1-cycle pulse from current owner: release grant
//   gnt_idx  out  2  index of granted requester (feeds decoder a[1:0])
//   gnt_vld  out  1  grant valid (feeds decoder en)
//   tmo      out  1  1-cycle pulse: grant revoked by timeout
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_vld=0, tmo=0.
//     - Reset mid-grant drops gnt_vld on the next edge, with no tmo pulse.
//   All outputs are registered; no combinational path from req/done to outputs.
//   FSM states: IDLE, GRANT.
//   IDLE:
//     - gnt_vld=0; gnt_idx holds its last value.
//     - If req!=0: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first
//       set bit as winner w.
//     - Next edge: gnt_idx<=w, gnt_vld<=1, hold_cnt<=0, state<=GRANT.
//       Latency is 1 cycle from req seen in IDLE to gnt_vld.
//     - If req==0: remain in IDLE.
//   GRANT:
//     - gnt_vld=1; gnt_idx stable for the whole grant.
//     - hold_cnt increments by 1 each cycle and saturates at 255.
//     - Release conditions, evaluated every cycle:
//       R1: done==1
//       R2: req[gnt_idx]==0
//       R3: MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1
//     - On any of R1..R3, next edge: gnt_vld<=0, ptr<=gnt_idx+1 (mod 4),
//       state<=IDLE.
//     - tmo<=1 only when R3 holds and neither R1 nor R2 does; done wins
//       over timeout in the same cycle.
//     - Maximum grant length is MAX_HOLD cycles of gnt_vld=1.
//   One mandatory IDLE bubble (gnt_vld=0) separates consecutive grants.
//   The decoder never sees a direct index change while enabled.
//   Requests arriving or changing during GRANT do not affect gnt_idx.
//   They are arbitrated on the next IDLE cycle.
//   done asserted in IDLE is ignored.
//   Fairness: after owner i releases, i has the lowest priority in the next
//   scan. With all 4 requesting continuously, the grant order is 0,1,2,3,0,...
//   Wrap-around: ptr 3 -> gnt_idx 3 -> ptr becomes 0.
//   tmo is high for exactly 1 cycle, coincident with the first gnt_vld=0 cycle.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with req=4'hF -> gnt_vld=0, gnt_idx=0, tmo=0
//     throughout.
//   2 Rotation: req=4'hF held, done pulsed 2 cycles after each grant ->
//     gnt_idx sequence 0,1,2,3,0 with a 1-cycle gnt_vld=0 gap between grants.
//   3 Skip/wrap: req=4'b1001, ptr=1 after grant 0 -> next grant 3, then 0.
//   4 Timeout: MAX_HOLD=4, req=4'h2 held, no done -> gnt_vld high exactly
//     4 cycles, then tmo=1 for 1 cycle, then gnt_idx=1 is regranted.
//   5 Collision: done=1 in the same cycle hold_cnt==MAX_HOLD-1 -> release
//     with tmo=0. Request drop: req[gnt_idx] cleared -> gnt_vld=0 next cycle.
//   6 Reset mid-grant: gnt_vld=1, gnt_idx=2, rst_n=0 -> gnt_vld=0, gnt_idx=0
//     next edge. After reset, req=4'hF -> gnt_idx=0.

Source files
------------

// File: rtl/rr_arb4_idx.sv
`default_nettype none
//============================================================================
// Module      : rr_arb4_idx
// Description : Four-requester round-robin arbiter with grant hold and
//               timeout. Presents the winner as a binary index plus a valid
//               qualifier, ready to drive the a[1:0]/en inputs of a
//               2-to-4 decoder.
// Ports       : clk      - system clock, rising edge
//               rst_n    - synchronous reset, active-low
//               req[3:0] - request vector, bit i = requester i
//               done     - one-cycle release pulse from the current owner
//               gnt_idx  - index of the granted requester
//               gnt_vld  - grant valid
//               tmo      - one-cycle pulse, grant revoked by timeout
// Revision    : 1.0 - initial release
//============================================================================
module rr_arb4_idx #(
    parameter int MAX_HOLD = 15     // 1..255 cycles; 0 disables the timeout
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    // Last hold_cnt value permitted before a forced release.
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam bit         TMO_EN    = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [7:0]  r_hold_cnt;

    logic [1:0]  w_win;
    logic        w_r1;
    logic        w_r2;
    logic        w_r3;
    logic        w_rel;

    // Rotating priority scan: r_ptr has highest priority, then upward mod 4.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        w_win = r_ptr;
        found = 1'b0;
        cand  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = r_ptr + 2'(i);
            if (!found && req[cand]) begin
                w_win = cand;
                found = 1'b1;
            end
        end
    end

    // Release terms while a grant is active.
    always_comb begin
        w_r1  = done;
        w_r2  = ~req[gnt_idx];
        w_r3  = TMO_EN && (r_hold_cnt == HOLD_LAST);
        w_rel = w_r1 | w_r2 | w_r3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
            gnt_idx    <= 2'd0;
            gnt_vld    <= 1'b0;
            tmo        <= 1'b0;
        end else begin
            tmo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done is deliberately ignored here.
                    if (|req) begin
                        gnt_idx    <= w_win;
                        gnt_vld    <= 1'b1;
                        r_hold_cnt <= 8'd0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (r_hold_cnt != 8'hFF) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                    if (w_rel) begin
                        gnt_vld <= 1'b0;
                        r_ptr   <= gnt_idx + 2'd1;  // releasing owner drops to lowest priority
                        r_state <= S_IDLE;
                        // done or a dropped request take precedence over timeout.
                        tmo     <= w_r3 & ~w_r1 & ~w_r2;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_idx.sv
`default_nettype none
//============================================================================
// Module      : tb_rr_arb4_idx
// Description : Self-checking bench for rr_arb4_idx: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_rr_arb4_idx;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    int n_cmp;
    int n_bad;

    // Behavioural model: who owns the bus, for how many cycles so far,
    // and who has top priority for the next scan.
    int m_idx;
    int m_vld;
    int m_tmo;
    int m_ptr;
    int m_age;

    rr_arb4_idx #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the currently applied inputs,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        int  k;
        int  cand;
        bit  found;
        bit  by_done;
        bit  by_drop;
        bit  by_time;
        if (!rst_n) begin
            m_idx = 0; m_vld = 0; m_tmo = 0; m_ptr = 0; m_age = 0;
        end else if (m_vld == 0) begin
            m_tmo = 0;
            found = 1'b0;
            for (k = 0; k < 4; k++) begin
                cand = (m_ptr + k) % 4;
                if (!found && req[cand]) begin
                    found = 1'b1;
                    m_idx = cand;
                end
            end
            if (found) begin
                m_vld = 1;
                m_age = 1;
            end
        end else begin
            by_done = done;
            by_drop = !req[m_idx];
            by_time = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
            m_tmo   = (by_time && !by_done && !by_drop) ? 1 : 0;
            if (by_done || by_drop || by_time) begin
                m_vld = 0;
                m_ptr = (m_idx + 1) % 4;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'hF; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %0b expected 0", gnt_vld); end
            n_cmp++;
            if (gnt_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx: got %0d expected 0", gnt_idx); end
            n_cmp++;
            if (tmo !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %0b expected 0", tmo); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [1:0] exp_idx;
        req = 4'hF; done = 1'b0;
        for (int g = 0; g < 5; g++) begin
            exp_idx = 2'(g % 4);
            tick();
            n_cmp++;
            if (gnt_vld !== 1'b1 || gnt_idx !== exp_idx) begin
                n_bad++;
                $display("FAIL rotation_grant%0d: got vld=%0b idx=%0d expected vld=1 idx=%0d", g, gnt_vld, gnt_idx, exp_idx);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            n_cmp++;
            if (gnt_vld !== 1'b0 || tmo !== 1'b0) begin
                n_bad++;
                $display("FAIL rotation_gap%0d: got vld=%0b tmo=%0b expected vld=0 tmo=0", g, gnt_vld, tmo);
            end
        end
    endtask

    task automatic test_skip_wrap();
        // Previous release was of requester 0, so requester 1 has top priority.
        req = 4'b1001; done = 1'b0;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd3) begin
            n_bad++; $display("FAIL skip_to3: got vld=%0b idx=%0d expected vld=1 idx=3", gnt_vld, gnt_idx);
        end
        done = 1'b1; tick(); done = 1'b0;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            n_bad++; $display("FAIL wrap_to0: got vld=%0b idx=%0d expected vld=1 idx=0", gnt_vld, gnt_idx);
        end
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic test_timeout();
        int high_cycles;
        req = 4'h2; done = 1'b0;
        high_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (gnt_vld === 1'b1 && gnt_idx === 2'd1 && tmo === 1'b0) high_cycles++;
        end
        n_cmp++;
        if (high_cycles != 4) begin
            n_bad++; $display("FAIL timeout_hold: got %0d high cycles expected 4", high_cycles);
        end
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b0 || tmo !== 1'b1) begin
            n_bad++; $display("FAIL timeout_pulse: got vld=%0b tmo=%0b expected vld=0 tmo=1", gnt_vld, tmo);
        end
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL timeout_regrant: got vld=%0b idx=%0d tmo=%0b expected vld=1 idx=1 tmo=0", gnt_vld, gnt_idx, tmo);
        end
    endtask

    task automatic test_collision();
        // Requester 1 currently in its first granted cycle.
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt_vld !== 1'b0 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL collision: got vld=%0b tmo=%0b expected vld=0 tmo=0", gnt_vld, tmo);
        end
        req = 4'h4;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
            n_bad++; $display("FAIL drop_grant: got vld=%0b idx=%0d expected vld=1 idx=2", gnt_vld, gnt_idx);
        end
        req = 4'h0;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b0 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL drop_release: got vld=%0b tmo=%0b expected vld=0 tmo=0", gnt_vld, tmo);
        end
    endtask

    task automatic test_mid_reset();
        req = 4'h4; done = 1'b0;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
            n_bad++; $display("FAIL midrst_grant: got vld=%0b idx=%0d expected vld=1 idx=2", gnt_vld, gnt_idx);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b0 || gnt_idx !== 2'd0 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL midrst_clear: got vld=%0b idx=%0d tmo=%0b expected vld=0 idx=0 tmo=0", gnt_vld, gnt_idx, tmo);
        end
        rst_n = 1'b1; req = 4'hF;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            n_bad++; $display("FAIL midrst_after: got vld=%0b idx=%0d expected vld=1 idx=0", gnt_vld, gnt_idx);
        end
        req = 4'h0; tick();
    endtask

    task automatic test_random();
        rst_n = 1'b0; req = 4'h0; done = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 6) == 0);
            tick();
            n_cmp++;
            if (gnt_vld !== 1'(m_vld)) begin
                n_bad++; $display("FAIL rand_vld cyc%0d: got %0b expected %0d", c, gnt_vld, m_vld);
            end
            n_cmp++;
            if (gnt_idx !== 2'(m_idx)) begin
                n_bad++; $display("FAIL rand_idx cyc%0d: got %0d expected %0d", c, gnt_idx, m_idx);
            end
            n_cmp++;
            if (tmo !== 1'(m_tmo)) begin
                n_bad++; $display("FAIL rand_tmo cyc%0d: got %0b expected %0d", c, tmo, m_tmo);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_idx = 0; m_vld = 0; m_tmo = 0; m_ptr = 0; m_age = 0;
        rst_n = 1'b0; req = 4'h0; done = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_timeout();
        test_collision();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
